// File: rtl/serial_inst_loader_if.sv
// Instruction-memory write port between serial_inst_loader and the memory.
//   master : driven by the loader (mem_we, mem_addr, mem_wdata)
//   slave  : observed by the instruction memory
interface serial_inst_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/serial_inst_loader.sv
// serial_inst_loader: deserialises an LSB-first, LANES-wide instruction stream
// (qualified by iwen, clocked by a slow pin sclk) into DATA_W-bit words and
// writes them to instruction memory at auto-incrementing addresses.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   iwen, sclk      asynchronous pin inputs (load enable, serial clock)
//   sdata[LANES]    serial data, lane k carries bit n*LANES+k on edge n
//   mem             memory write port (mem_we, mem_addr, mem_wdata)
//   word_cnt        words written in the current session
//   busy, done      session active / one-cycle end-of-session pulse
//   overflow        sticky, a word was dropped because memory was full
//   parity_err      sticky parity mismatch (only with LOADER_PARITY_EN)
// Optional feature: define LOADER_PARITY_EN to require an even-parity bit on
// sdata[0] after every word; mismatching words are not written.
module serial_inst_loader #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LANES       = 1,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iwen,
    input  logic                  sclk,
    input  logic [LANES-1:0]      sdata,
    serial_inst_loader_if.master  mem,
    output logic [ADDR_W:0]       word_cnt,
    output logic                  busy,
    output logic                  done,
`ifdef LOADER_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  overflow
);
    localparam int unsigned BEATS    = DATA_W / LANES;
    localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CAPACITY = (1 << ADDR_W) - START_ADDR;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef LOADER_PARITY_EN
        PARITY,
`endif
        WRITE
    } state_e;

    state_e                             state_q, state_d;
    logic [SYNC_STAGES-1:0]             iwen_sync_q, iwen_sync_d;
    logic [SYNC_STAGES-1:0]             sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0][LANES-1:0]  sdata_sync_q, sdata_sync_d;
    logic                               iwen_prev_q, iwen_prev_d;
    logic                               sclk_prev_q, sclk_prev_d;
    logic [CNT_W-1:0]                   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]                  shift_q, shift_d;
    logic                               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]                  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]                  mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]                    word_cnt_q, word_cnt_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               overflow_q, overflow_d;
    logic                               parity_err_q, parity_err_d;

    logic             iwen_s, sclk_s;
    logic [LANES-1:0] sdata_s;
    logic             iwen_rise, iwen_fall, sclk_rise, full;

    // All three pins are taken from the same synchroniser stage so they stay aligned.
    assign iwen_s    = iwen_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
    assign iwen_rise = iwen_s & ~iwen_prev_q;
    assign iwen_fall = ~iwen_s & iwen_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign full      = (word_cnt_q == (ADDR_W+1)'(CAPACITY));

    // Next-state and output computation.
    always_comb begin
        state_d      = state_q;
        iwen_sync_d  = {iwen_sync_q[SYNC_STAGES-2:0], iwen};
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
        iwen_prev_d  = iwen_s;
        sclk_prev_d  = sclk_s;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_cnt_d   = word_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        parity_err_d = parity_err_q;

        // Address/count advance the cycle after a write; the address saturates.
        if (mem_we_q) begin
            word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
            if (mem_addr_q != {ADDR_W{1'b1}}) begin
                mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (iwen_rise) begin
                    state_d      = SHIFT;
                    mem_addr_d   = ADDR_W'(START_ADDR);
                    word_cnt_d   = '0;
                    overflow_d   = 1'b0;
                    parity_err_d = 1'b0;
                    bit_cnt_d    = '0;
                    busy_d       = 1'b1;
                end
            end
            SHIFT: begin
                if (iwen_fall) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if (sclk_rise) begin
                    shift_d = {sdata_s, shift_q[DATA_W-1:LANES]};
                    if (bit_cnt_q == CNT_W'(BEATS-1)) begin
                        bit_cnt_d = '0;
`ifdef LOADER_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = WRITE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef LOADER_PARITY_EN
            PARITY: begin
                if (iwen_fall) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if (sclk_rise) begin
                    // Even parity: word bits plus parity bit must XOR to zero.
                    if ((^shift_q) ^ sdata_s[0]) begin
                        parity_err_d = 1'b1;
                        state_d      = SHIFT;
                    end else begin
                        state_d      = WRITE;
                    end
                end
            end
`endif
            WRITE: begin
                if (full) begin
                    overflow_d  = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = shift_q;
                end
                // A write already under way completes even if iwen drops now.
                if (iwen_fall) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    state_d   = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            iwen_sync_q  <= '0;
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            iwen_prev_q  <= 1'b0;
            sclk_prev_q  <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= ADDR_W'(START_ADDR);
            mem_wdata_q  <= '0;
            word_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            iwen_sync_q  <= iwen_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            iwen_prev_q  <= iwen_prev_d;
            sclk_prev_q  <= sclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_cnt_q   <= word_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign word_cnt      = word_cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
`ifdef LOADER_PARITY_EN
    assign parity_err    = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_q;
`endif
endmodule

// File: tb/tb_serial_inst_loader.sv
// Testbench for serial_inst_loader: three instances (default, small memory
// with START_ADDR=1, four lanes) driven through pin-level tasks; expected
// writes go into per-instance queues and are popped as mem_we appears.
module tb_serial_inst_loader;
    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] iwen;
    logic [2:0] sclk_p;
    logic [3:0] sd [3];
    logic [2:0] busy_o, done_o, ovf_o, perr_o;
    logic [8:0] wc0, wc2;
    logic [2:0] wc1;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt [3];
    exp_t sb [3][$];

    always #5 clk = ~clk;

    serial_inst_loader_if #(.DATA_W(32), .ADDR_W(8)) m0 ();
    serial_inst_loader_if #(.DATA_W(32), .ADDR_W(2)) m1 ();
    serial_inst_loader_if #(.DATA_W(32), .ADDR_W(8)) m2 ();

    serial_inst_loader #(.DATA_W(32), .LANES(1), .ADDR_W(8), .START_ADDR(0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .iwen(iwen[0]), .sclk(sclk_p[0]), .sdata(sd[0][0:0]), .mem(m0),
        .word_cnt(wc0), .busy(busy_o[0]), .done(done_o[0]),
`ifdef LOADER_PARITY_EN
        .parity_err(perr_o[0]),
`endif
        .overflow(ovf_o[0]));

    serial_inst_loader #(.DATA_W(32), .LANES(1), .ADDR_W(2), .START_ADDR(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst(rst), .iwen(iwen[1]), .sclk(sclk_p[1]), .sdata(sd[1][0:0]), .mem(m1),
        .word_cnt(wc1), .busy(busy_o[1]), .done(done_o[1]),
`ifdef LOADER_PARITY_EN
        .parity_err(perr_o[1]),
`endif
        .overflow(ovf_o[1]));

    serial_inst_loader #(.DATA_W(32), .LANES(4), .ADDR_W(8), .START_ADDR(0), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst(rst), .iwen(iwen[2]), .sclk(sclk_p[2]), .sdata(sd[2]), .mem(m2),
        .word_cnt(wc2), .busy(busy_o[2]), .done(done_o[2]),
`ifdef LOADER_PARITY_EN
        .parity_err(perr_o[2]),
`endif
        .overflow(ovf_o[2]));

`ifndef LOADER_PARITY_EN
    assign perr_o = 3'b000;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] wcnt(input int d);
        case (d)
            0:       return 64'(wc0);
            1:       return 64'(wc1);
            default: return 64'(wc2);
        endcase
    endfunction

    task automatic sb_pop(input int d, input logic [7:0] addr, input logic [31:0] data);
        exp_t e;
        if (sb[d].size() == 0) begin
            chk($sformatf("unexpected_write%0d", d), 64'(addr), 64'hffff_ffff);
        end else begin
            e = sb[d].pop_front();
            chk($sformatf("wr_addr%0d", d), 64'(addr), 64'(e.addr));
            chk($sformatf("wr_data%0d", d), 64'(data), 64'(e.data));
        end
    endtask

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (m0.mem_we) sb_pop(0, m0.mem_addr, m0.mem_wdata);
        if (m1.mem_we) sb_pop(1, 8'(m1.mem_addr), m1.mem_wdata);
        if (m2.mem_we) sb_pop(2, m2.mem_addr, m2.mem_wdata);
        for (int i = 0; i < 3; i++) if (done_o[i]) done_cnt[i]++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk period of 8 clk cycles with sdata held across the rise.
    task automatic beat(input int d, input logic [3:0] v);
        sd[d] = v;
        tick(4);
        sclk_p[d] = 1'b1;
        tick(4);
        sclk_p[d] = 1'b0;
    endtask

    task automatic send_word(input int d, input int lanes, input logic [31:0] w, input int nbeats,
                             input logic flip, input logic exp_wr, input logic [7:0] addr);
        logic [31:0] v;
        if (exp_wr) sb[d].push_back('{addr: addr, data: w});
        for (int i = 0; i < nbeats; i++) begin
            v = (w >> (i * lanes)) & ((32'd1 << lanes) - 32'd1);
            beat(d, v[3:0]);
        end
`ifdef LOADER_PARITY_EN
        if (nbeats == 32 / lanes) beat(d, {3'b000, (^w) ^ flip});
`else
        if (flip) sd[d] = 4'h0;
`endif
        tick(6);
    endtask

    task automatic start(input int d);
        iwen[d] = 1'b1;
        tick(6);
        chk($sformatf("busy_on%0d", d), 64'(busy_o[d]), 64'd1);
    endtask

    task automatic stop(input int d);
        int n0;
        n0 = done_cnt[d];
        iwen[d] = 1'b0;
        for (int k = 0; k < 40 && done_cnt[d] == n0; k++) tick(1);
        chk($sformatf("done_pulse%0d", d), 64'(done_cnt[d] - n0), 64'd1);
        chk($sformatf("busy_off%0d", d), 64'(busy_o[d]), 64'd0);
        tick(2);
    endtask

    logic [31:0] prog [9] = '{32'h1304500a, 32'ha32e8006, 32'h1305f00e, 32'ha32fa006, 32'h9304000f,
                              32'h232f9006, 32'h232e0006, 32'h0326c007, 32'h33068600};

    initial begin
        rst = 1'b1;
        iwen = '0;
        sclk_p = '0;
        for (int i = 0; i < 3; i++) begin
            sd[i] = '0;
            done_cnt[i] = 0;
        end
        tick(3);
        chk("rst_we", 64'(m0.mem_we), 64'd0);
        chk("rst_addr0", 64'(m0.mem_addr), 64'd0);
        chk("rst_addr1", 64'(m1.mem_addr), 64'd1);
        chk("rst_wc", wcnt(0), 64'd0);
        chk("rst_flags", 64'({busy_o, done_o, ovf_o, perr_o}), 64'd0);
        rst = 1'b0;
        tick(2);

        // Single word.
        start(0);
        send_word(0, 1, 32'h1304500a, 32, 1'b0, 1'b1, 8'd0);
        chk("single_wc", wcnt(0), 64'd1);
        stop(0);

        // Nine-word program.
        start(0);
        for (int i = 0; i < 9; i++) send_word(0, 1, prog[i], 32, 1'b0, 1'b1, 8'(i));
        chk("prog_wc", wcnt(0), 64'd9);
        chk("prog_ovf", 64'(ovf_o[0]), 64'd0);
        stop(0);

        // Partial word discarded, then a fresh session restarts at address 0.
        start(0);
        send_word(0, 1, 32'ha32e8006, 10, 1'b0, 1'b0, 8'd0);
        stop(0);
        chk("partial_wc", wcnt(0), 64'd0);
        start(0);
        send_word(0, 1, 32'h1305f00e, 32, 1'b0, 1'b1, 8'd0);
        chk("restart_wc", wcnt(0), 64'd1);
        stop(0);

        // Capacity: START_ADDR=1 in a 4-word memory leaves room for 3.
        start(1);
        for (int i = 0; i < 3; i++) send_word(1, 1, prog[i], 32, 1'b0, 1'b1, 8'(i + 1));
        chk("cap_ovf_before", 64'(ovf_o[1]), 64'd0);
        send_word(1, 1, prog[3], 32, 1'b0, 1'b0, 8'd0);
        chk("cap_ovf", 64'(ovf_o[1]), 64'd1);
        chk("cap_wc", wcnt(1), 64'd3);
        chk("cap_addr_hold", 64'(m1.mem_addr), 64'd3);
        stop(1);
        chk("cap_ovf_sticky", 64'(ovf_o[1]), 64'd1);
        start(1);
        chk("cap_ovf_clear", 64'(ovf_o[1]), 64'd0);
        chk("cap_wc_clear", wcnt(1), 64'd0);
        chk("cap_addr_start", 64'(m1.mem_addr), 64'd1);
        stop(1);

        // Four lanes: nibble per edge, LSB nibble first.
        start(2);
        send_word(2, 4, 32'ha32e8006, 8, 1'b0, 1'b1, 8'd0);
        chk("lane4_wc", wcnt(2), 64'd1);
        stop(2);

        // Reset in the middle of a word drops it and clears everything.
        start(2);
        send_word(2, 4, 32'h1305f00e, 5, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        iwen[2] = 1'b0;
        tick(1);
        chk("midrst_we", 64'(m2.mem_we), 64'd0);
        chk("midrst_wc", wcnt(2), 64'd0);
        chk("midrst_flags", 64'({busy_o[2], done_o[2], ovf_o[2], perr_o[2]}), 64'd0);
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("midrst_idle", 64'(busy_o[2]), 64'd0);
        chk("midrst_addr", 64'(m2.mem_addr), 64'd0);

`ifdef LOADER_PARITY_EN
        // Good parity is written; a flipped parity bit drops the word.
        start(0);
        send_word(0, 1, 32'h9304000f, 32, 1'b0, 1'b1, 8'd0);
        chk("par_ok_err", 64'(perr_o[0]), 64'd0);
        send_word(0, 1, 32'h232f9006, 32, 1'b1, 1'b0, 8'd0);
        chk("par_err", 64'(perr_o[0]), 64'd1);
        chk("par_wc", wcnt(0), 64'd1);
        stop(0);
`endif

        tick(10);
        for (int i = 0; i < 3; i++) chk($sformatf("sb_empty%0d", i), 64'(sb[i].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
